// File: rtl/pwm_multichannel.sv
// Multichannel PWM generator: one shared prescaled counter (edge- or center-aligned),
// per-channel shadow/active duty registers that swap at the period boundary.
module pwm_multichannel #(
  parameter int NUM_CH  = 16,
  parameter int CNT_W   = 8,
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_CH-1:0]  en_out,
  input  logic [NUM_CH-1:0]  en_pwm,
  input  logic               duty_wr,
  input  logic [4:0]         duty_ch,
  input  logic [CNT_W-1:0]   duty_data,
  input  logic [CNT_W-1:0]   period,
  input  logic [PRESC_W-1:0] prescale,
  input  logic               center,
  output logic [NUM_CH-1:0]  out,
  output logic               period_tick
);

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic               dir_q, dir_d;
  logic [CNT_W-1:0]   period_q;
  logic               center_q;
  logic [NUM_CH-1:0]  out_q, out_d;
  logic               period_tick_q;
  logic               tick;
  logic               boundary;
  logic               wr_valid;

  // >= rather than == so a prescale lowered below the running count cannot stall for a full wrap
  assign tick     = (presc_q >= prescale);
  assign cnt_inc  = cnt_q + 1'b1;
  assign wr_valid = duty_wr && (int'(duty_ch) < NUM_CH);

  // Center mode runs 0..P then P-1..1; the boundary is taken on the tick that would
  // step down from 1, so the period is exactly 2*P ticks (a single tick when P == 0).
  always_comb begin
    boundary = 1'b0;
    if (tick) begin
      if (center_q) begin
        boundary = (period_q == '0) || (dir_q && (cnt_q == CNT_W'(1)));
      end else begin
        boundary = (cnt_q == period_q);
      end
    end
  end

  always_comb begin
    presc_d = tick ? '0 : presc_q + 1'b1;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    if (boundary) begin
      cnt_d = '0;
      dir_d = 1'b0;
    end else if (tick) begin
      if (!center_q || !dir_q) begin
        cnt_d = cnt_inc;
        if (center_q && (cnt_inc == period_q)) begin
          dir_d = 1'b1;
        end
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic             wr_hit;
      logic [CNT_W-1:0] shadow_q, shadow_d, active_q;

      assign wr_hit   = wr_valid && (duty_ch == 5'(gi));
      // Writes landing on the boundary cycle bypass straight into the active copy
      assign shadow_d = wr_hit ? duty_data : shadow_q;
      assign out_d[gi] = en_out[gi] & (en_pwm[gi] ? (cnt_q < active_q) : 1'b1);

      always_ff @(posedge clk) begin
        if (rst) begin
          shadow_q <= '0;
          active_q <= '0;
        end else begin
          shadow_q <= shadow_d;
          if (boundary) begin
            active_q <= shadow_d;
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q       <= '0;
      cnt_q         <= '0;
      dir_q         <= 1'b0;
      period_q      <= '0;
      center_q      <= 1'b0;
      out_q         <= '0;
      period_tick_q <= 1'b0;
    end else begin
      presc_q       <= presc_d;
      cnt_q         <= cnt_d;
      dir_q         <= dir_d;
      out_q         <= out_d;
      period_tick_q <= boundary;
      if (boundary) begin
        period_q <= period;
        center_q <= center;
      end
    end
  end

  assign out         = out_q;
  assign period_tick = period_tick_q;

endmodule

// File: tb/tb_pwm_multichannel.sv
// Bench for pwm_multichannel: directed scenarios plus randomized traffic, all checked
// cycle by cycle against a phase-based model of the waveform.
module tb_pwm_multichannel;

  localparam int NCH = 16;

  logic           clk;
  logic           rst;
  logic [NCH-1:0] en_out;
  logic [NCH-1:0] en_pwm;
  logic           duty_wr;
  logic [4:0]     duty_ch;
  logic [7:0]     duty_data;
  logic [7:0]     period;
  logic [7:0]     prescale;
  logic           center;
  logic [NCH-1:0] out;
  logic           period_tick;

  pwm_multichannel #(.NUM_CH(NCH), .CNT_W(8), .PRESC_W(8)) dut (
    .clk(clk), .rst(rst), .en_out(en_out), .en_pwm(en_pwm),
    .duty_wr(duty_wr), .duty_ch(duty_ch), .duty_data(duty_data),
    .period(period), .prescale(prescale), .center(center),
    .out(out), .period_tick(period_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: position within the period as a tick index; counter value derived from it.
  int             m_presc, m_phase, m_P;
  bit             m_C;
  int             m_shadow[NCH];
  int             m_active[NCH];
  logic [NCH-1:0] exp_out;
  logic           exp_tick;

  int hi_cnt[NCH];
  int tick_pos;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    int len, c;
    bit tk, bnd;
    if (rst) begin
      m_presc = 0; m_phase = 0; m_P = 0; m_C = 0;
      for (int i = 0; i < NCH; i++) begin
        m_shadow[i] = 0;
        m_active[i] = 0;
      end
      exp_out  = '0;
      exp_tick = 1'b0;
      return;
    end
    len = m_C ? ((m_P == 0) ? 1 : 2 * m_P) : m_P + 1;
    c   = (m_C && m_phase > m_P) ? 2 * m_P - m_phase : m_phase;
    for (int i = 0; i < NCH; i++) begin
      exp_out[i] = en_out[i] && (!en_pwm[i] || c < m_active[i]);
    end
    tk  = (m_presc == int'(prescale));
    bnd = tk && (m_phase == len - 1);
    m_presc = tk ? 0 : m_presc + 1;
    if (duty_wr && int'(duty_ch) < NCH) m_shadow[int'(duty_ch)] = int'(duty_data);
    if (bnd) begin
      m_P = int'(period);
      m_C = center;
      for (int i = 0; i < NCH; i++) m_active[i] = m_shadow[i];
      m_phase = 0;
    end else if (tk) begin
      m_phase++;
    end
    exp_tick = bnd;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_val("out", 32'(out), 32'(exp_out));
    check_val("period_tick", 32'(period_tick), 32'(exp_tick));
  endtask

  task automatic write_cycle(input int ch, input int data);
    duty_wr   = 1'b1;
    duty_ch   = 5'(ch);
    duty_data = 8'(data);
    cycle();
    duty_wr   = 1'b0;
  endtask

  task automatic wait_tick(input int budget);
    int n = 0;
    cycle();
    while (period_tick !== 1'b1 && n < budget) begin
      cycle();
      n++;
    end
    check_val("tick_seen", 32'(period_tick), 32'd1);
  endtask

  task automatic measure(input int len);
    tick_pos = 0;
    for (int i = 0; i < NCH; i++) hi_cnt[i] = 0;
    for (int k = 1; k <= len; k++) begin
      cycle();
      for (int i = 0; i < NCH; i++) if (out[i] === 1'b1) hi_cnt[i]++;
      if (period_tick === 1'b1 && tick_pos == 0) tick_pos = k;
    end
  endtask

  initial begin
    rst = 1'b1; en_out = '0; en_pwm = '0; duty_wr = 1'b0; duty_ch = '0;
    duty_data = '0; period = 8'd9; prescale = 8'd0; center = 1'b0;
    repeat (3) cycle();
    check_val("reset_out", 32'(out), 32'd0);
    check_val("reset_tick", 32'(period_tick), 32'd0);
    $display("step reset: out=%h period_tick=%b", out, period_tick);

    // Edge basic and extremes
    rst = 1'b0; en_out = 16'h0027; en_pwm = 16'h0027;
    write_cycle(0, 3);
    write_cycle(1, 0);
    write_cycle(2, 255);
    wait_tick(40);
    wait_tick(40);
    measure(10);
    check_val("edge_ch0_high", 32'(hi_cnt[0]), 32'd3);
    check_val("edge_tick_pos", 32'(tick_pos), 32'd10);
    check_val("duty0_ch1_high", 32'(hi_cnt[1]), 32'd0);
    check_val("duty255_ch2_high", 32'(hi_cnt[2]), 32'd10);
    $display("step edge: ch0=%0d ch1=%0d ch2=%0d tick_pos=%0d", hi_cnt[0], hi_cnt[1], hi_cnt[2], tick_pos);

    // Shadow write mid-period, then a write landing on the boundary cycle
    cycle(); cycle();
    write_cycle(0, 7);
    measure(7);
    check_val("shadow_hold_high", 32'(hi_cnt[0]), 32'd0);
    check_val("shadow_hold_tick", 32'(tick_pos), 32'd7);
    measure(10);
    check_val("shadow_new_high", 32'(hi_cnt[0]), 32'd7);
    repeat (9) cycle();
    write_cycle(0, 5);
    check_val("bypass_tick", 32'(period_tick), 32'd1);
    measure(10);
    check_val("bypass_high", 32'(hi_cnt[0]), 32'd5);
    $display("step shadow: ch0_high=%0d tick_pos=%0d", hi_cnt[0], tick_pos);

    // Enables and an out-of-range write
    en_pwm[5] = 1'b0;
    cycle();
    check_val("static_high", 32'(out[5]), 32'd1);
    en_out[5] = 1'b0;
    cycle();
    check_val("out_disabled", 32'(out[5]), 32'd0);
    write_cycle(NCH, 9);
    wait_tick(40);
    measure(10);
    check_val("invalid_wr_ch0", 32'(hi_cnt[0]), 32'd5);
    check_val("invalid_wr_ch2", 32'(hi_cnt[2]), 32'd10);
    $display("step enables: ch0_high=%0d ch2_high=%0d", hi_cnt[0], hi_cnt[2]);

    // Reset at cnt == 5, restart with a new period
    wait_tick(40);
    repeat (5) cycle();
    rst = 1'b1; period = 8'd6;
    cycle();
    check_val("midrst_out", 32'(out), 32'd0);
    check_val("midrst_tick", 32'(period_tick), 32'd0);
    rst = 1'b0;
    write_cycle(0, 5);
    check_val("restart_tick", 32'(period_tick), 32'd1);
    measure(7);
    check_val("restart_ch0", 32'(hi_cnt[0]), 32'd5);
    check_val("restart_ch2", 32'(hi_cnt[2]), 32'd0);
    check_val("restart_tick_pos", 32'(tick_pos), 32'd7);
    $display("step midreset: ch0_high=%0d tick_pos=%0d", hi_cnt[0], tick_pos);

    // Prescaler with center-aligned counting
    rst = 1'b1; prescale = 8'd3; period = 8'd4; center = 1'b1;
    cycle();
    rst = 1'b0;
    write_cycle(0, 2);
    wait_tick(80);
    wait_tick(80);
    measure(32);
    check_val("center_ch0_high", 32'(hi_cnt[0]), 32'd12);
    check_val("center_tick_pos", 32'(tick_pos), 32'd32);
    $display("step center: ch0_high=%0d tick_pos=%0d", hi_cnt[0], tick_pos);

    // Randomized segments, each starting from a reset with fresh timing settings
    for (int seg = 0; seg < 6; seg++) begin
      rst = 1'b1;
      prescale = 8'($urandom_range(0, 2));
      period   = 8'($urandom_range(0, 12));
      center   = 1'($urandom_range(0, 1));
      cycle();
      rst = 1'b0;
      en_out = 16'($urandom);
      en_pwm = 16'($urandom);
      for (int k = 0; k < 250; k++) begin
        if ($urandom_range(0, 15) == 0) en_out = 16'($urandom);
        if ($urandom_range(0, 15) == 0) en_pwm = 16'($urandom);
        if ($urandom_range(0, 31) == 0) period = 8'($urandom_range(0, 12));
        if ($urandom_range(0, 31) == 0) center = 1'($urandom_range(0, 1));
        duty_wr   = ($urandom_range(0, 3) == 0);
        duty_ch   = 5'($urandom_range(0, 20));
        duty_data = ($urandom_range(0, 7) == 0) ? 8'd255 : 8'($urandom_range(0, 15));
        cycle();
      end
      duty_wr = 1'b0;
      $display("step random seg=%0d prescale=%0d total=%0d bad=%0d", seg, prescale, total, bad);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
